// File: rtl/polar_encoder_pkg.sv
// polar_encoder_pkg
// Shared constants for the polar encoder and its decoder partner:
//   ENC_N / ENC_K      codeword length and info bits per frame
//   INFO_POS           packed table, INFO_POS[8k +: 8] = codeword index of info bit k
//                      (strictly ascending, last entry = 255)
//   enc_state_t        encoder FSM state encodings
//   beat / stage widths for the streaming interfaces
// No ports (package).
package polar_encoder_pkg;

  localparam int ENC_N      = 256;
  localparam int ENC_K      = 128;
  localparam int ENC_STAGES = 8;

  localparam int IN_W    = 8;   // info bits per input beat
  localparam int OUT_W   = 16;  // codeword bits per output beat
  localparam int BEAT_W  = 4;   // 16 beats per frame on both sides
  localparam int STAGE_W = 3;   // 8 butterfly stages

  // Decoder side: LLR word used by the successive-cancellation decoder.
  typedef logic signed [5:0] dec_llr_t;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_SCAT = 2'd1,
    ST_ENC  = 2'd2,
    ST_OUT  = 2'd3
  } enc_state_t;

  // Info bits occupy the upper half of the index space: INFO_POS[k] = 128 + k.
  function automatic logic [ENC_K*8-1:0] build_info_pos();
    logic [ENC_K*8-1:0] r_tab;
    r_tab = '0;
    for (int k = 0; k < ENC_K; k++) begin
      r_tab[8*k +: 8] = 8'(ENC_N - ENC_K + k);
    end
    return r_tab;
  endfunction

  localparam logic [ENC_K*8-1:0] INFO_POS = build_info_pos();

  // Elaboration-time lookup: is codeword index n carrying an info bit?
  function automatic bit pos_is_info(input int n);
    bit found;
    found = 1'b0;
    for (int k = 0; k < ENC_K; k++) begin
      if (int'(INFO_POS[8*k +: 8]) == n) found = 1'b1;
    end
    return found;
  endfunction

endpackage

// File: rtl/polar_enc_stage.sv
// polar_enc_stage
// Combinational butterfly for one stage of x = u * F^{(x)8}, F = [[1,0],[1,1]].
// For stage s, every index i with bit s clear becomes v[i] ^ v[i + 2^s];
// indices with bit s set pass through. F is its own inverse over GF(2), so
// this is exactly the bit-combine the decoder applies in the other direction.
// Ports:
//   i_vec    256-bit working vector
//   i_stage  stage number 0..7
//   o_vec    vector after the selected stage
module polar_enc_stage
  import polar_encoder_pkg::*;
(
  input  logic [ENC_N-1:0]   i_vec,
  input  logic [STAGE_W-1:0] i_stage,
  output logic [ENC_N-1:0]   o_vec
);

  logic [ENC_N-1:0] w_res [ENC_STAGES];

  for (genvar s = 0; s < ENC_STAGES; s++) begin : g_stage
    for (genvar i = 0; i < ENC_N; i++) begin : g_bit
      if (((i >> s) & 1) == 0) begin : g_xor
        assign w_res[s][i] = i_vec[i] ^ i_vec[i + (1 << s)];
      end else begin : g_pass
        assign w_res[s][i] = i_vec[i];
      end
    end
  end

  assign o_vec = w_res[i_stage];

endmodule

// File: rtl/polar_encoder.sv
// polar_encoder
// Streaming polar encoder, N=256, K=128. Collects 16 info beats of 8 bits,
// scatters them into the info positions (frozen positions = 0), runs 8
// butterfly stages one per cycle, then streams 16 codeword beats of 16 bits.
// Handshake (both sides): a beat transfers on a rising edge where valid and
// ready are both 1; the source holds data stable while valid=1 and ready=0.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  input beat handshake, in_data[7:0] = info[8b+7:8b]
//   out_valid/out_ready output beat handshake, out_data[15:0] = x[16j+15:16j]
//   out_last           high with output beat 15
//   dbg_state          current FSM state (enc_state_t encoding)
module polar_encoder
  import polar_encoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  output logic [1:0]        dbg_state
);

  localparam logic [BEAT_W-1:0]  LAST_BEAT  = '1;
  localparam logic [STAGE_W-1:0] LAST_STAGE = '1;

  enc_state_t          r_state;
  enc_state_t          w_state_nxt;
  logic [BEAT_W-1:0]   r_beat;
  logic [STAGE_W-1:0]  r_stage;
  logic [ENC_K-1:0]    r_info;
  logic [ENC_N-1:0]    r_cw;
  logic [ENC_N-1:0]    w_scat;
  logic [ENC_N-1:0]    w_stage_out;

  // Scatter: fixed wiring from the INFO_POS table, frozen bits tied low.
  for (genvar k = 0; k < ENC_K; k++) begin : g_info
    assign w_scat[INFO_POS[8*k +: 8]] = r_info[k];
  end
  for (genvar n = 0; n < ENC_N; n++) begin : g_frozen
    if (!pos_is_info(n)) begin : g_zero
      assign w_scat[n] = 1'b0;
    end
  end

  polar_enc_stage u_stage (
    .i_vec   (r_cw),
    .i_stage (r_stage),
    .o_vec   (w_stage_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_LOAD;
      r_beat  <= '0;
      r_stage <= '0;
      r_info  <= '0;
      r_cw    <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_LOAD: begin
          if (in_valid) begin
            r_info[{r_beat, 3'b000} +: IN_W] <= in_data;
            r_beat <= r_beat + 4'd1;  // wraps to 0 after beat 15
          end
        end
        ST_SCAT: begin
          r_cw    <= w_scat;
          r_stage <= '0;
        end
        ST_ENC: begin
          r_cw    <= w_stage_out;
          r_stage <= r_stage + 3'd1;
        end
        ST_OUT: begin
          if (out_ready) r_beat <= r_beat + 4'd1;  // back to 0 for next LOAD
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    out_last    = 1'b0;
    case (r_state)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (r_beat == LAST_BEAT)) w_state_nxt = ST_SCAT;
      end
      ST_SCAT: w_state_nxt = ST_ENC;
      ST_ENC: begin
        if (r_stage == LAST_STAGE) w_state_nxt = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        out_data  = r_cw[{r_beat, 4'b0000} +: OUT_W];
        out_last  = (r_beat == LAST_BEAT);
        if (out_ready && (r_beat == LAST_BEAT)) w_state_nxt = ST_LOAD;
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  assign dbg_state = r_state;

endmodule

// File: doc/polar_encoder.md
POLAR_ENCODER -- requirements
Module: polar_encoder

Interface
REQ-001 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-002 Constant ENC_N, default 256, meaning codeword length in bits (`BIT_N`).
REQ-003 Constant ENC_K, default 128, meaning info bits per frame (`BIT_K`).
REQ-004 Constant INFO_POS[0..127], 8 bits per entry, meaning codeword index of info bit k; entries are strictly ascending and INFO_POS[127] = 255.
REQ-005 clk  input  1  rising-edge system clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  in_data beat valid.
REQ-008 in_ready  output  1  block accepts an input beat.
REQ-009 in_data  input  8  info beat b: bit j = info[8b+j].
REQ-010 out_valid  output  1  out_data beat valid.
REQ-011 out_ready  input  1  downstream accepts an output beat.
REQ-012 out_data  output  16  codeword beat j: bit i = x[16j+i].
REQ-013 out_last  output  1  high with beat 15 of each frame.

Function
REQ-014 FSM states SHALL be LOAD, SCAT, ENC and OUT.
REQ-015 LOAD: in_ready=1; a beat transfers when in_valid & in_ready; a 4-bit beat counter stores beat b into info[8b+7:8b]; transfer of beat 15 → SCAT.
REQ-016 SCAT (1 cycle): cw <= 0 with cw[INFO_POS[k]] = info[k] for all k; frozen positions = 0; → ENC, stage=0.
REQ-017 ENC: for stage s = 0..7, one stage per cycle: for every i with bit s of i = 0, cw[i] <= cw[i] ^ cw[i+2^s]; after s=7 → OUT.
REQ-018 The result SHALL be x = u·F^{⊗8}, F=[[1,0],[1,1]], natural order, no bit reversal: x[i] = XOR of u[j] over all j with (j & i) == i.
REQ-019 OUT: out_valid=1 and out_data = cw[16j+15:16j] for beat counter j; the beat advances only when out_ready=1; out_last=1 when j=15; transfer of beat 15 → LOAD, counter=0.
REQ-020 out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 in_ready SHALL be 0 outside LOAD; out_valid SHALL be 0 outside OUT.
REQ-022 Latency: the first output beat is valid 10 cycles after the cycle in which input beat 15 transfers; minimum frame period is 41 cycles.
REQ-023 in_valid gaps in LOAD SHALL only stall the beat counter; partial frames persist indefinitely.
REQ-024 out_ready may be held 1 continuously, giving one beat per cycle.

Reset
REQ-025 On rst=1 at a clock edge: state=LOAD, beat counter=0, stage=0, info=0 and cw=0.
REQ-026 During and after reset, in_ready=1 (LOAD) and out_valid=0, out_data=0 and out_last=0.
REQ-027 Reset in any state SHALL discard the frame in progress, with no partial output.

Structure
REQ-028 ENC_N, ENC_K, INFO_POS, the state encodings and the beat widths SHALL reside in the shared defines file alongside the decoder constants.
REQ-029 One sub-module, polar_enc_stage, SHALL apply the combinational butterfly for a given stage to a 256-bit vector; it is the exact inverse partner of the decoder bit-combine.
REQ-030 The scatter SHALL be a generate loop over INFO_POS; no run-time mask scanning.

Verification
REQ-031 Scenario: all-zero info, out_ready=1 → 16 beats of 0x0000, out_last on beat 15, first beat 10 cycles after the last input beat.
REQ-032 Scenario: only info[127]=1 (u[255]) → all 16 beats 0xFFFF.
REQ-033 Scenario: all-ones info → each beat equals the bench golden model x=u·F^{⊗8}; a decoder loopback with noiseless LLRs returns info.
REQ-034 Scenario: out_ready toggled 1010… and held 0 for 5 cycles at beat 7 → beat values unchanged while stalled, no beat lost or duplicated, in_ready=0 throughout.
REQ-035 Scenario: rst pulsed in cycle 4 of ENC → next cycle out_valid=0 and in_ready=1; the following full frame encodes correctly.
REQ-036 Scenario: in_valid gapped randomly across 3 back-to-back frames → outputs match the golden model frame-by-frame.
